// File: rtl/traffic_gen_pkg.sv
// traffic_gen_pkg: shared types, LFSR constants and helpers for the traffic generator
package traffic_gen_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int ING_W = 16;
  localparam int SEQ_W = 48;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/traffic_gen_ingress_if.sv
// traffic_gen_ingress_if: flit valid/ready channel into a NoC ingress port
interface traffic_gen_ingress_if import traffic_gen_pkg::*; #(parameter int EG_W = 2);
  logic valid;
  logic ready;
  logic head;
  logic tail;
  logic [EG_W-1:0] egress_id;
  logic [ING_W+SEQ_W-1:0] unique_id;
  logic [63:0] timestamp;
  modport master(output valid, head, tail, egress_id, unique_id, timestamp, input ready);
  modport slave(input valid, head, tail, egress_id, unique_id, timestamp, output ready);
endinterface

// File: rtl/traffic_gen_lfsr.sv
// traffic_gen_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with advance enable
module traffic_gen_lfsr import traffic_gen_pkg::*; #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) value <= (SEED == 16'd0) ? DEFAULT_SEED : SEED;
    else if (advance) value <= lfsr_next(value);
endmodule

// File: rtl/traffic_gen_ingress.sv
// traffic_gen_ingress: Bernoulli-injection packet generator driving one NoC ingress port
module traffic_gen_ingress import traffic_gen_pkg::*; #(
  parameter logic [15:0] INGRESS_ID = 16'd0,
  parameter int N_EGRESS = 4,
  parameter int MAX_FLITS = 4,
  parameter int LEN_RANDOM = 1,
  parameter int N_PACKETS = 0,
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter int EG_W = (N_EGRESS > 1) ? $clog2(N_EGRESS) : 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] rate,
  input  logic [63:0] current_cycle,
  traffic_gen_ingress_if.master flit_out,
  output logic [31:0] pkts_sent,
  output logic [31:0] flits_sent,
  output logic [31:0] stall_cycles,
  output logic        done
);
  state_e state, state_n;
  logic [15:0] r;
  logic [7:0] len, idx, len_new;
  logic [SEQ_W-1:0] seq;
  logic inject, fire, last;
  traffic_gen_lfsr #(.SEED(SEED)) u_lfsr (
    .clock(clock), .reset(reset), .advance(state == WAIT), .value(r)
  );
  assign inject = (r < rate) || (rate == 16'hFFFF);
  assign fire = flit_out.valid && flit_out.ready;
  assign last = (N_PACKETS != 0) && (pkts_sent + 32'd1 == 32'(N_PACKETS));
  assign len_new = (LEN_RANDOM != 0)
    ? 8'((({8'd0, r[15:8]} * 16'(MAX_FLITS)) >> 8) + 16'd1) : 8'(MAX_FLITS);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = enable ? WAIT : IDLE;
      WAIT: state_n = !enable ? IDLE : inject ? SEND : WAIT;
      SEND: state_n = !(fire && flit_out.tail) ? SEND : last ? DONE : enable ? WAIT : IDLE;
      default: state_n = DONE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // Flit fields are loaded only on injection and advanced only on handshake, so they hold under backpressure
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      flit_out.valid <= 1'b0;
      flit_out.head <= 1'b0;
      flit_out.tail <= 1'b0;
      flit_out.egress_id <= '0;
      flit_out.unique_id <= '0;
      flit_out.timestamp <= '0;
      len <= '0;
      idx <= '0;
      seq <= '0;
      pkts_sent <= '0;
      flits_sent <= '0;
      stall_cycles <= '0;
      done <= 1'b0;
    end else begin
      flit_out.valid <= state_n == SEND;
      done <= state_n == DONE;
      if (state == WAIT && state_n == SEND) begin
        flit_out.head <= 1'b1;
        flit_out.tail <= len_new == 8'd1;
        flit_out.egress_id <= EG_W'(({8'd0, r[7:0]} * 16'(N_EGRESS)) >> 8);
        flit_out.unique_id <= {INGRESS_ID, seq};
        flit_out.timestamp <= current_cycle;
        len <= len_new;
        idx <= '0;
      end
      if (fire) begin
        flits_sent <= sat_inc(flits_sent);
        flit_out.head <= 1'b0;
        if (flit_out.tail) begin
          flit_out.tail <= 1'b0;
          pkts_sent <= sat_inc(pkts_sent);
          seq <= seq + 1'b1;
        end else begin
          flit_out.tail <= idx + 8'd2 == len;
          idx <= idx + 8'd1;
        end
      end
      if (flit_out.valid && !flit_out.ready) stall_cycles <= sat_inc(stall_cycles);
    end
endmodule

// File: doc/traffic_gen_ingress.md
Name: traffic_gen_ingress

Overview:
- Synthesizable, parametrised successor to the simulation-only ingress traffic model.
- Generates packetised flit traffic for one NoC ingress port with an LFSR-driven Bernoulli injection process, random or fixed destination and length, and per-packet unique IDs and timestamps.
- Sits between the test harness and a NoC ingress port, so traffic evaluation runs on FPGA/emulation without DPI.
- Reports packet, flit and backpressure statistics plus a sticky done flag.

Parameters:
- INGRESS_ID, 0: value placed in flit_out_unique_id[63:48].
- N_EGRESS, 4: number of legal destinations, 1..256.
- MAX_FLITS, 4: maximum packet length in flits, 1..255.
- LEN_RANDOM, 1: 1 = uniform length 1..MAX_FLITS; 0 = every packet has MAX_FLITS flits.
- N_PACKETS, 0: packet budget before done; 0 = unlimited.
- SEED, 16'hACE1: LFSR seed; 0 is replaced by 16'hACE1.
- EG_W, $clog2(N_EGRESS) (minimum 1): egress ID width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allow new packets; never interrupts a packet in flight.
- rate  in  16  injection threshold per WAIT cycle; 16'hFFFF = inject every cycle.
- current_cycle  in  64  free-running cycle count, used as timestamp.
- flit_out_ready  in  1  downstream accept.
- flit_out_valid  out  1  flit present.
- flit_out_head  out  1  first flit of packet.
- flit_out_tail  out  1  last flit of packet.
- flit_out_egress_id  out  EG_W  destination.
- flit_out_unique_id  out  64  {INGRESS_ID[15:0], seq[47:0]}.
- flit_out_timestamp  out  64  current_cycle at packet creation.
- pkts_sent  out  32  completed packets.
- flits_sent  out  32  accepted flits.
- stall_cycles  out  32  cycles with valid && !ready.
- done  out  1  packet budget exhausted; sticky.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - State IDLE; all outputs 0; seq = 0.
  - LFSR = SEED, or 16'hACE1 when SEED = 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances only in cycles spent in WAIT.
- FSM states:
  - IDLE: if enable, go to WAIT next cycle.
  - WAIT: draw r = current LFSR value. Inject if (r < rate) || rate == 16'hFFFF. If !enable, go to IDLE.
  - On injection, latch:
    - egress = (r[7:0] * N_EGRESS) >> 8
    - len = LEN_RANDOM ? 1 + ((r[15:8] * MAX_FLITS) >> 8) : MAX_FLITS
    - unique_id = {INGRESS_ID, seq}
    - timestamp = current_cycle
  - After injection go to SEND. flit_out_valid rises the next cycle, so decision-to-valid latency is 1 cycle.
  - SEND: valid = 1.
    - head = 1 on flit index 0 only; tail = 1 when index == len-1. A single-flit packet has head = tail = 1.
    - egress_id, unique_id and timestamp are constant for the whole packet.
    - On valid && ready, increment flits_sent; if not tail, increment the index.
    - On the tail handshake, increment pkts_sent and seq. Then:
      - if N_PACKETS != 0 and pkts_sent+1 == N_PACKETS, go to DONE;
      - else if enable, go to WAIT;
      - else go to IDLE.
  - DONE: valid = 0, done = 1 until reset. enable is ignored.
- Handshake rules:
  - valid is never retracted and flit fields are never changed while valid && !ready.
  - Zero-bubble flits within a packet: the next flit is valid the cycle after a handshake.
  - Exactly one idle (WAIT) cycle separates consecutive packets.
- Outputs: all outputs are registered. No combinational path from flit_out_ready to any output.
- Counters: all counters saturate at 2^32-1. seq wraps at 2^48.
- enable dropping mid-packet: the packet completes normally, then the FSM goes to IDLE.
- rate = 0: no injection ever; the LFSR still advances in WAIT.

Decomposition:
- Package traffic_gen_pkg:
  - state enum (IDLE, WAIT, SEND, DONE)
  - LFSR taps and default seed constants
  - unique-ID field split: 16-bit ingress, 48-bit seq
- Sub-module traffic_gen_lfsr: 16-bit Galois LFSR with advance enable and seed. It is reused by the planned synthesizable egress checker.

Test Plan:
- Fixed packets, always ready: SEED=16'hACE1, rate=FFFF, LEN_RANDOM=0, MAX_FLITS=3, N_PACKETS=2, ready=1.
  - Expect flits H,-,T / (1 gap) / H,-,T, seq 0 then 1.
  - Then done=1, pkts_sent=2, flits_sent=6.
- Backpressure: hold ready=0 for 5 cycles on flit 1.
  - Expect valid and all fields stable for those cycles.
  - Expect stall_cycles=5; no flit lost or duplicated.
- Single-flit packets: MAX_FLITS=1 -> every flit has head=tail=1 and seq increments per flit.
- Enable drop mid-packet: enable=0 after the head of a 4-flit packet.
  - Expect the packet to complete, then IDLE with no new head.
  - Re-enable -> next packet carries seq+1.
- rate=0 for 1000 cycles -> valid never asserts and counters stay 0. Random mode over 10k packets with N_EGRESS=3 -> egress_id always <3 and len always in 1..MAX_FLITS.
- Async reset asserted mid-SEND -> valid=0 immediately, counters 0, LFSR reseeded. After release, the first packet matches the packet produced after the initial reset.
